// File: rtl/player_status_pkg.sv
// Shared types and constants for the player-status bookkeeping stage.
package burger_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ALIVE,
    DYING,
    INVULN,
    DEAD
  } status_state_t;

  localparam logic [15:0] SCORE_MAX = 16'hFFFF;

  typedef logic [15:0] piece_mask_t;

endpackage

// File: rtl/player_status_if.sv
// Signal bundle between the sprite/controller side and the player-status stage.
interface player_status_if;

  logic       game_idle;
  logic       game_start;
  logic       frame_tick;
  logic       enemy_hit;
  logic       piece_landed;
  logic [3:0] piece_id;

  logic        lives;
  logic [1:0]  lives_count;
  logic        burger_done;
  logic        player_freeze;
  logic        invulnerable;
  logic [15:0] score;

  modport master (
    output game_idle, game_start, frame_tick, enemy_hit, piece_landed, piece_id,
    input  lives, lives_count, burger_done, player_freeze, invulnerable, score
  );

  modport slave (
    input  game_idle, game_start, frame_tick, enemy_hit, piece_landed, piece_id,
    output lives, lives_count, burger_done, player_freeze, invulnerable, score
  );

endinterface

// File: rtl/player_status_frame_timer.sv
// 8-bit frame countdown; zero_o pulses on the tick that takes the count from 1 to 0.
module frame_timer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       tick_i,
  output logic       zero_o
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i)
      count_d = '0;
    else if (load_i)
      count_d = load_val_i;
    else if (tick_i && (count_q != 8'd0))
      count_d = count_q - 8'd1;
  end

  // Kept independent of load_i so the owner can reload on this same pulse.
  assign zero_o = tick_i && (count_q == 8'd1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

// File: rtl/player_status.sv
// Per-round lives, death/respawn sequencing, landed-piece mask and score.
module player_status
  import burger_pkg::*;
#(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned NUM_PIECES    = 16,
  parameter int unsigned DEATH_FRAMES  = 60,
  parameter int unsigned INVULN_FRAMES = 120,
  parameter int unsigned PIECE_POINTS  = 50
) (
  input  logic             clock,
  input  logic             reset_n,
  player_status_if.slave   bus
);

  localparam logic [1:0]  LIVES_INIT  = 2'(START_LIVES);
  localparam logic [4:0]  PIECES_LIM  = 5'(NUM_PIECES);
  localparam logic [15:0] POINTS      = 16'(PIECE_POINTS);
  localparam piece_mask_t VALID_MASK  = piece_mask_t'((33'h1 << NUM_PIECES) - 33'h1);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? SCORE_MAX : sum[15:0];
  endfunction

  status_state_t state_q, state_d;
  logic [1:0]    lives_count_q, lives_count_d;
  piece_mask_t   mask_q, mask_d;
  logic [15:0]   score_q, score_d;
  logic          done_q, done_d;
  logic          lives_q, lives_d;
  logic          freeze_q, freeze_d;
  logic          invuln_q, invuln_d;

  logic       in_round, land_ok, first_land, hit_ok;
  logic       timer_clear, timer_load, timer_run, timer_zero;
  logic [7:0] timer_val;

  assign in_round   = (state_q == ALIVE) || (state_q == DYING) || (state_q == INVULN);
  assign land_ok    = bus.piece_landed && bus.game_start && in_round &&
                      ({1'b0, bus.piece_id} < PIECES_LIM);
  assign first_land = land_ok && !mask_q[bus.piece_id];

  always_comb begin
    mask_d  = mask_q;
    score_d = score_q;
    if (bus.game_idle) begin
      mask_d  = '0;
      score_d = '0;
    end else begin
      if (land_ok)
        mask_d[bus.piece_id] = 1'b1;
      if (first_land)
        score_d = sat_add(score_q, POINTS);
    end
  end

  assign done_d = &(mask_d | ~VALID_MASK);

  // A hit in the same cycle as the completing landing loses to the landing.
  assign hit_ok = (state_q == ALIVE) && bus.enemy_hit && !bus.game_idle && !done_d;

  always_comb begin
    lives_count_d = lives_count_q;
    if (bus.game_idle)
      lives_count_d = LIVES_INIT;
    else if (hit_ok)
      lives_count_d = lives_count_q - 2'd1;
  end

  assign timer_clear = bus.game_idle || (state_q == IDLE);
  assign timer_run   = bus.frame_tick && ((state_q == DYING) || (state_q == INVULN));
  assign timer_load  = hit_ok || ((state_q == DYING) && timer_zero && (lives_count_q != 2'd0));
  assign timer_val   = hit_ok ? 8'(DEATH_FRAMES) : 8'(INVULN_FRAMES);

  frame_timer u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear_i    (timer_clear),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .tick_i     (timer_run),
    .zero_o     (timer_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.game_idle) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.game_start) state_d = ALIVE;
        ALIVE:   if (hit_ok)         state_d = DYING;
        DYING:   if (timer_zero)     state_d = (lives_count_q == 2'd0) ? DEAD : INVULN;
        INVULN:  if (timer_zero)     state_d = ALIVE;
        DEAD:    state_d = DEAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // Status levels are decoded from the next state so they register alongside it.
  always_comb begin
    lives_d  = (state_d != DEAD);
    freeze_d = (state_d == DYING);
    invuln_d = (state_d == INVULN);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lives_count_q <= LIVES_INIT;
      mask_q        <= '0;
      score_q       <= '0;
      done_q        <= 1'b0;
      lives_q       <= 1'b1;
      freeze_q      <= 1'b0;
      invuln_q      <= 1'b0;
    end else begin
      lives_count_q <= lives_count_d;
      mask_q        <= mask_d;
      score_q       <= score_d;
      done_q        <= done_d;
      lives_q       <= lives_d;
      freeze_q      <= freeze_d;
      invuln_q      <= invuln_d;
    end
  end

  assign bus.lives         = lives_q;
  assign bus.lives_count   = lives_count_q;
  assign bus.burger_done   = done_q;
  assign bus.player_freeze = freeze_q;
  assign bus.invulnerable  = invuln_q;
  assign bus.score         = score_q;

endmodule

// File: tb/tb_player_status.sv
// Directed bench: a default-parameter instance plus a small one (1 life, 4 pieces, short timers).
module tb_player_status;

  logic clock;
  logic reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  player_status_if bus();
  player_status_if bs();

  player_status dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  player_status #(
    .START_LIVES   (1),
    .NUM_PIECES    (4),
    .DEATH_FRAMES  (2),
    .INVULN_FRAMES (2),
    .PIECE_POINTS  (50)
  ) dut_small (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      bus.frame_tick = 1'b1;
      bs.frame_tick  = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      bs.frame_tick  = 1'b0;
      step();
    end
  endtask

  task automatic hit();
    bus.enemy_hit = 1'b1;
    step();
    bus.enemy_hit = 1'b0;
  endtask

  task automatic land(input logic [3:0] id);
    bus.piece_landed = 1'b1;
    bus.piece_id     = id;
    step();
    bus.piece_landed = 1'b0;
  endtask

  task automatic land_s(input logic [3:0] id);
    bs.piece_landed = 1'b1;
    bs.piece_id     = id;
    step();
    bs.piece_landed = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.game_idle = 0; bus.game_start = 0; bus.frame_tick = 0;
    bus.enemy_hit = 0; bus.piece_landed = 0; bus.piece_id = '0;
    bs.game_idle  = 0; bs.game_start  = 0; bs.frame_tick  = 0;
    bs.enemy_hit  = 0; bs.piece_landed  = 0; bs.piece_id  = '0;
    step();
    step();

    chk("rst_lives",  16'(bus.lives), 16'd1);
    chk("rst_count",  16'(bus.lives_count), 16'd3);
    chk("rst_score",  bus.score, 16'd0);
    chk("rst_done",   16'(bus.burger_done), 16'd0);
    chk("rst_freeze", 16'(bus.player_freeze), 16'd0);
    chk("rst_invuln", 16'(bus.invulnerable), 16'd0);

    reset_n = 1'b1;
    bus.game_idle = 1'b1;
    step();
    bus.game_idle  = 1'b0;
    bus.game_start = 1'b1;
    step();
    chk("start_count", 16'(bus.lives_count), 16'd3);
    chk("start_lives", 16'(bus.lives), 16'd1);
    chk("start_score", bus.score, 16'd0);
    tick(3);
    chk("alive_tick_freeze", 16'(bus.player_freeze), 16'd0);

    // Hit with a simultaneous tick: that tick must not count toward the 60.
    bus.enemy_hit  = 1'b1;
    bus.frame_tick = 1'b1;
    step();
    bus.enemy_hit  = 1'b0;
    bus.frame_tick = 1'b0;
    chk("hit1_freeze", 16'(bus.player_freeze), 16'd1);
    chk("hit1_count",  16'(bus.lives_count), 16'd2);
    chk("hit1_invuln", 16'(bus.invulnerable), 16'd0);
    tick(59);
    chk("dying59_freeze", 16'(bus.player_freeze), 16'd1);
    chk("dying59_invuln", 16'(bus.invulnerable), 16'd0);
    tick(1);
    chk("dying60_freeze", 16'(bus.player_freeze), 16'd0);
    chk("dying60_invuln", 16'(bus.invulnerable), 16'd1);
    chk("dying60_count",  16'(bus.lives_count), 16'd2);
    hit();
    chk("invhit_count",  16'(bus.lives_count), 16'd2);
    chk("invhit_invuln", 16'(bus.invulnerable), 16'd1);
    tick(119);
    chk("inv119_invuln", 16'(bus.invulnerable), 16'd1);
    tick(1);
    chk("inv120_invuln", 16'(bus.invulnerable), 16'd0);
    chk("inv120_freeze", 16'(bus.player_freeze), 16'd0);

    hit();
    chk("hit2_count", 16'(bus.lives_count), 16'd1);
    hit();
    chk("dyhit_count",  16'(bus.lives_count), 16'd1);
    chk("dyhit_freeze", 16'(bus.player_freeze), 16'd1);
    tick(60);
    chk("hit2_inv", 16'(bus.invulnerable), 16'd1);
    tick(120);
    chk("hit2_alive", 16'(bus.invulnerable), 16'd0);

    hit();
    chk("hit3_count",  16'(bus.lives_count), 16'd0);
    chk("hit3_lives",  16'(bus.lives), 16'd1);
    chk("hit3_freeze", 16'(bus.player_freeze), 16'd1);
    tick(59);
    chk("hit3_59_lives", 16'(bus.lives), 16'd1);
    tick(1);
    chk("dead_lives",  16'(bus.lives), 16'd0);
    chk("dead_freeze", 16'(bus.player_freeze), 16'd0);
    chk("dead_invuln", 16'(bus.invulnerable), 16'd0);
    hit();
    tick(5);
    chk("dead_hold_lives", 16'(bus.lives), 16'd0);
    chk("dead_hold_count", 16'(bus.lives_count), 16'd0);

    bus.game_start = 1'b0;
    bus.game_idle  = 1'b1;
    step();
    step();
    chk("restart_count", 16'(bus.lives_count), 16'd3);
    chk("restart_lives", 16'(bus.lives), 16'd1);
    bus.game_idle  = 1'b0;
    bus.game_start = 1'b1;
    step();

    for (int p = 0; p < 15; p++) begin
      land(4'(p));
      chk("land_score", bus.score, 16'(50 * (p + 1)));
      if (p == 5) begin
        land(4'd5);
        chk("repeat5_score", bus.score, 16'd300);
      end
    end
    // Id 20 wraps to 4 on the 4-bit port, arriving as a repeat landing.
    land(4'(20));
    chk("id20_score", bus.score, 16'd750);
    chk("pre_done",   16'(bus.burger_done), 16'd0);

    bus.enemy_hit = 1'b1;
    land(4'd15);
    bus.enemy_hit = 1'b0;
    chk("final_done",   16'(bus.burger_done), 16'd1);
    chk("final_score",  bus.score, 16'd800);
    chk("final_count",  16'(bus.lives_count), 16'd3);
    chk("final_freeze", 16'(bus.player_freeze), 16'd0);
    hit();
    chk("done_hit_count",  16'(bus.lives_count), 16'd3);
    chk("done_hit_freeze", 16'(bus.player_freeze), 16'd0);
    step();
    step();
    chk("done_sticky", 16'(bus.burger_done), 16'd1);

    bus.game_idle = 1'b1;
    step();
    bus.game_idle = 1'b0;
    step();
    chk("reround_done",  16'(bus.burger_done), 16'd0);
    chk("reround_score", bus.score, 16'd0);
    land(4'd0);
    chk("reround_land", bus.score, 16'd50);
    hit();
    tick(10);
    chk("mid_dying_freeze", 16'(bus.player_freeze), 16'd1);
    reset_n = 1'b0;
    #1;
    chk("async_freeze", 16'(bus.player_freeze), 16'd0);
    chk("async_count",  16'(bus.lives_count), 16'd3);
    chk("async_score",  bus.score, 16'd0);
    chk("async_lives",  16'(bus.lives), 16'd1);
    chk("async_invuln", 16'(bus.invulnerable), 16'd0);
    chk("async_done",   16'(bus.burger_done), 16'd0);
    bus.game_start = 1'b0;
    step();
    step();

    reset_n = 1'b1;
    bs.game_idle = 1'b1;
    step();
    bs.game_idle  = 1'b0;
    bs.game_start = 1'b1;
    step();
    chk("s_start_count", 16'(bs.lives_count), 16'd1);
    bs.enemy_hit = 1'b1;
    step();
    bs.enemy_hit = 1'b0;
    chk("s_hit_count",  16'(bs.lives_count), 16'd0);
    chk("s_hit_freeze", 16'(bs.player_freeze), 16'd1);
    tick(1);
    chk("s_tick1_freeze", 16'(bs.player_freeze), 16'd1);
    tick(1);
    chk("s_dead_lives",  16'(bs.lives), 16'd0);
    chk("s_dead_freeze", 16'(bs.player_freeze), 16'd0);
    chk("s_dead_invuln", 16'(bs.invulnerable), 16'd0);
    bs.game_idle = 1'b1;
    step();
    step();
    bs.game_idle = 1'b0;
    step();
    chk("s_restart_count", 16'(bs.lives_count), 16'd1);
    chk("s_restart_lives", 16'(bs.lives), 16'd1);
    land_s(4'd4);
    chk("s_oor_score", bs.score, 16'd0);
    chk("s_oor_done",  16'(bs.burger_done), 16'd0);
    for (int p = 0; p < 4; p++) begin
      land_s(4'(p));
      chk("s_land_score", bs.score, 16'(50 * (p + 1)));
    end
    chk("s_done", 16'(bs.burger_done), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
